serial_word_capture: RTL and testbench

Downstream stage of the negative-edge D flip-flop with synchronous clear. It consumes the flop's `q` bitstream as a serial line and frames it into WIDTH-bit parallel words. Each word is presented on a valid/ready output handshake. Framing faults and overruns are flagged.

---
 rtl/serial_capture_pkg.sv | 19 +
 rtl/serial_word_capture_if.sv | 30 +++
 rtl/sipo_shift.sv | 32 +++
 rtl/serial_word_capture.sv | 177 +++++++++++++++++
 tb/tb_serial_word_capture.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/serial_capture_pkg.sv
// Shared types and line-level constants for the serial word capture block.
//   state_e    : framing FSM states
//   IdleLevel  : line level between frames
//   StartLevel : level that opens a frame
//   StopLevel  : level that must close a frame
package serial_capture_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StStop   = 2'd3
  } state_e;

  localparam logic IdleLevel  = 1'b0;
  localparam logic StartLevel = 1'b1;
  localparam logic StopLevel  = 1'b0;

endpackage

// File: rtl/serial_word_capture_if.sv
// Serial line in / parallel word out bundle for serial_word_capture.
//   sin        : serial line (bench/upstream -> capture)
//   dready     : consumer accepts dout
//   dout       : captured word, LSB = first data bit
//   dvalid     : dout holds an unconsumed word
//   frame_err  : one-cycle pulse, bad stop bit
//   parity_err : one-cycle pulse, parity mismatch
//   overrun    : one-cycle pulse, completed word dropped
// master drives the line and consumes words; slave is the capture block.
interface serial_word_capture_if #(
  parameter int unsigned Width = 8
);
  logic             sin;
  logic             dready;
  logic [Width-1:0] dout;
  logic             dvalid;
  logic             frame_err;
  logic             parity_err;
  logic             overrun;

  modport master (
    output sin, dready,
    input  dout, dvalid, frame_err, parity_err, overrun
  );

  modport slave (
    input  sin, dready,
    output dout, dvalid, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/sipo_shift.sv
// Width-bit serial-in parallel-out register. Shifts right so that after Width
// enabled cycles the first bit shifted in sits in bit 0.
//   clk_i  : clock
//   rst_ni : asynchronous active-low clear
//   en_i   : shift enable
//   d_i    : serial data in
//   q_o    : parallel contents
module sipo_shift #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) q_d = {d_i, q_q[Width-1:1]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/serial_word_capture.sv
// Frames a serial bitstream (idle 0, start 1, Width data bits LSB first,
// optional even parity, stop 0) into Width-bit words on a valid/ready output.
// Optional feature: define SERIAL_CAPTURE_PARITY_EN to add the parity bit and
// make parity_err live; otherwise parity_err is tied 0.
//   clk_i  : clock, line sampled on rising edge
//   clr_ni : asynchronous active-low reset
//   bus    : serial_word_capture_if slave (sin, dready in; dout, dvalid,
//            frame_err, parity_err, overrun out, all registered)
module serial_word_capture
  import serial_capture_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic                   clk_i,
  input  logic                   clr_ni,
  serial_word_capture_if.slave   bus
);

  localparam int unsigned CntW = $clog2(Width);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              last_bit;
  logic              shift_en;
  logic              load;
  logic              frame_err_set;
  logic              par_err_set;
  logic [Width-1:0]  word;

  logic [Width-1:0]  dout_q, dout_d;
  logic              dvalid_q, dvalid_d;
  logic              frame_err_q;
  logic              overrun_q, overrun_d;

`ifdef SERIAL_CAPTURE_PARITY_EN
  logic par_q, par_d;   // running even parity of the data bits
  logic bad_q, bad_d;   // parity mismatch seen in this frame
  logic parity_err_q;
`endif

  assign last_bit = (cnt_q == CntW'(Width - 1));

  sipo_shift #(
    .Width (Width)
  ) u_sipo (
    .clk_i  (clk_i),
    .rst_ni (clr_ni),
    .en_i   (shift_en),
    .d_i    (bus.sin),
    .q_o    (word)
  );

  // State register
  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
`ifdef SERIAL_CAPTURE_PARITY_EN
      par_q   <= 1'b0;
      bad_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_CAPTURE_PARITY_EN
      par_q   <= par_d;
      bad_q   <= bad_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.sin == StartLevel) state_d = StData;
`ifdef SERIAL_CAPTURE_PARITY_EN
      StData:   if (last_bit) state_d = StParity;
      StParity: state_d = StStop;
`else
      StData:   if (last_bit) state_d = StStop;
`endif
      StStop:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath control per state
  always_comb begin
    cnt_d         = cnt_q;
    shift_en      = 1'b0;
    load          = 1'b0;
    frame_err_set = 1'b0;
    par_err_set   = 1'b0;
`ifdef SERIAL_CAPTURE_PARITY_EN
    par_d         = par_q;
    bad_d         = bad_q;
`endif
    unique case (state_q)
      StIdle: begin
        // Counter only ever restarts here, so it is never free-running.
        cnt_d = '0;
`ifdef SERIAL_CAPTURE_PARITY_EN
        par_d = 1'b0;
        bad_d = 1'b0;
`endif
      end
      StData: begin
        shift_en = 1'b1;
        cnt_d    = cnt_q + 1'b1;
`ifdef SERIAL_CAPTURE_PARITY_EN
        par_d    = par_q ^ bus.sin;
`endif
      end
      StStop: begin
        frame_err_set = (bus.sin != StopLevel);
`ifdef SERIAL_CAPTURE_PARITY_EN
        par_err_set   = bad_q;
`endif
        load          = !frame_err_set && !par_err_set;
      end
      default: begin
`ifdef SERIAL_CAPTURE_PARITY_EN
        if (state_q == StParity) bad_d = (bus.sin != par_q);
`endif
      end
    endcase
  end

  // Output handshake: a new word may replace one that transfers on this edge.
  always_comb begin
    dout_d    = dout_q;
    dvalid_d  = dvalid_q;
    overrun_d = 1'b0;
    if (load) begin
      if (!dvalid_q || bus.dready) begin
        dout_d   = word;
        dvalid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (dvalid_q && bus.dready) begin
      dvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      dout_q       <= '0;
      dvalid_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SERIAL_CAPTURE_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      dout_q       <= dout_d;
      dvalid_q     <= dvalid_d;
      frame_err_q  <= frame_err_set;
      overrun_q    <= overrun_d;
`ifdef SERIAL_CAPTURE_PARITY_EN
      parity_err_q <= par_err_set;
`endif
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dvalid    = dvalid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
`ifdef SERIAL_CAPTURE_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_capture.sv
// Self-checking bench for serial_word_capture. A frame-level reference model
// (held word + valid flag) predicts the output after every clock.
module tb_serial_word_capture;

  localparam int unsigned Width = 8;

`ifdef SERIAL_CAPTURE_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  logic clk;
  logic clr_n;

  serial_word_capture_if #(.Width(Width)) bus ();

  serial_word_capture #(
    .Width (Width)
  ) dut (
    .clk_i  (clk),
    .clr_ni (clr_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [Width-1:0] m_word;
  logic             m_valid;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input bit ferr, input bit perr, input bit ovr);
    check_eq({tag, " dvalid"}, 32'(bus.dvalid), 32'(m_valid));
    check_eq({tag, " dout"}, 32'(bus.dout), 32'(m_word));
    check_eq({tag, " frame_err"}, 32'(bus.frame_err), 32'(ferr));
    check_eq({tag, " parity_err"}, 32'(bus.parity_err), 32'(perr));
    check_eq({tag, " overrun"}, 32'(bus.overrun), 32'(ovr));
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic tick(input logic s, input logic r);
    @(negedge clk);
    bus.sin    = s;
    bus.dready = r;
    @(posedge clk);
    #1;
  endtask

  // mode: 0 = dready low, 1 = high, 2 = random
  task automatic idle(input int n, input int mode);
    logic r;
    for (int i = 0; i < n; i++) begin
      r = (mode == 2) ? 1'($urandom) : 1'(mode);
      tick(1'b0, r);
      if (m_valid && r) m_valid = 1'b0;
      check_outputs("idle", 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [Width-1:0] data, input logic stop,
                            input logic flip, input logic rdy);
    bit good;
    bit ovr;
    bit perr;
    tick(1'b1, 1'b0);
    check_outputs("start", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(Width); i++) tick(data[i], 1'b0);
    if (ParityEn) tick((^data) ^ flip, 1'b0);
    tick(stop, rdy);
    perr = ParityEn && flip;
    good = (stop == 1'b0) && !perr;
    ovr  = 1'b0;
    if (good) begin
      if (!m_valid || rdy) begin
        m_word  = data;
        m_valid = 1'b1;
      end else begin
        ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    check_outputs("stop", stop, perr, ovr);
  endtask

  initial begin
    m_word     = '0;
    m_valid    = 1'b0;
    clr_n      = 1'b0;
    bus.sin    = 1'b0;
    bus.dready = 1'b0;
    #12;
    check_outputs("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clr_n = 1'b1;
    idle(2, 0);

    // Basic capture, held with dready low
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    // Back-to-back frame while A5 is still held -> overrun
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    // Transfer and load on the same stop edge
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    idle(1, 1);

    // Bad stop bit; the trailing 1 must not open a new frame
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(int'(Width) + 4, 0);

    // Mid-frame reset with a word held
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    @(negedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    m_word  = '0;
    m_valid = 1'b0;
    check_outputs("midreset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.sin = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    idle(1, 0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    idle(1, 1);

    if (ParityEn) begin
      send_frame(8'h07, 1'b0, 1'b1, 1'b0);
      idle(1, 0);
      send_frame(8'h07, 1'b0, 1'b0, 1'b0);
      idle(1, 1);
    end

    // Randomized frames, gaps and consumer behaviour
    for (int k = 0; k < 60; k++) begin
      send_frame(Width'($urandom), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0), 1'($urandom));
      idle(int'($urandom_range(0, 3)), 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
